// File: rtl/excp_flush_ctrl_pkg.sv
// rtl/excp_flush_ctrl_pkg.sv - shared codes, exception tag indices and state encoding
package excp_flush_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUB_ADEF = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    // Bit positions inside wb_exc_vec = {adem, ale, brk, sys, ine, adef}
    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;
    localparam int EXC_ADEM = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esub;
    } exc_code_t;

    // Fixed-priority pick: interrupt first, then fetch-side faults, then
    // decode/trap instructions, then memory-side faults.
    function automatic exc_code_t exc_prio(input logic intr, input logic [5:0] vec);
        exc_code_t r;
        r.ecode = 6'h00;
        r.esub  = 9'd0;
        if (intr) begin
            r.ecode = ECODE_INT;
        end else if (vec[EXC_ADEF]) begin
            r.ecode = ECODE_ADE;
            r.esub  = ESUB_ADEF;
        end else if (vec[EXC_INE]) begin
            r.ecode = ECODE_INE;
        end else if (vec[EXC_SYS]) begin
            r.ecode = ECODE_SYS;
        end else if (vec[EXC_BRK]) begin
            r.ecode = ECODE_BRK;
        end else if (vec[EXC_ALE]) begin
            r.ecode = ECODE_ALE;
        end else if (vec[EXC_ADEM]) begin
            r.ecode = ECODE_ADE;
            r.esub  = ESUB_ADEM;
        end
        return r;
    endfunction

endpackage

// File: rtl/outst_counter.sv
// rtl/outst_counter.sv - saturating outstanding-transaction counter with sticky error
module outst_counter #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic req,
    input  logic resp,
    output logic zero_next,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_err_evt;

    // Next count; an overflowing increment or underflowing decrement holds the count
    always_comb begin
        w_cnt_next = r_cnt;
        w_err_evt  = 1'b0;
        if (req && !resp) begin
            if (r_cnt == CNT_MAX) w_err_evt  = 1'b1;
            else                  w_cnt_next = r_cnt + 1'b1;
        end else if (resp && !req) begin
            if (r_cnt == '0) w_err_evt  = 1'b1;
            else             w_cnt_next = r_cnt - 1'b1;
        end
    end

    // Count register and sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_err_evt) r_err <= 1'b1;
        end
    end

    assign zero_next = (w_cnt_next == '0);
    assign err       = r_err;

endmodule

// File: rtl/excp_flush_ctrl.sv
// rtl/excp_flush_ctrl.sv - exception/ERTN commit, flush drain and single redirect
module excp_flush_ctrl
    import excp_flush_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [5:0]  wb_exc_vec,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    input  logic        inst_req_hs,
    input  logic        inst_resp_hs,
    input  logic        data_req_hs,
    input  logic        data_resp_hs,
    input  logic        redirect_ready,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        ertn_flush,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ctrl_busy,
    output logic        cnt_err
);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_target;
    logic        w_trap;
    logic        w_ret;
    logic        w_drained;
    logic        w_inst_zero;
    logic        w_data_zero;
    logic        w_inst_err;
    logic        w_data_err;
    exc_code_t   w_code;

    outst_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .req       (inst_req_hs),
        .resp      (inst_resp_hs),
        .zero_next (w_inst_zero),
        .err       (w_inst_err)
    );

    outst_counter #(.CNT_W(CNT_W)) u_data_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .req       (data_req_hs),
        .resp      (data_resp_hs),
        .zero_next (w_data_zero),
        .err       (w_data_err)
    );

    // Triggers are only recognised in IDLE and never while reset is held,
    // so a held reset cannot leak a CSR strobe.
    assign w_trap    = resetn && (r_state == ST_IDLE) && wb_valid && (has_int || (|wb_exc_vec));
    assign w_ret     = resetn && (r_state == ST_IDLE) && wb_valid && wb_ertn && !w_trap;
    assign w_drained = w_inst_zero && w_data_zero;
    assign w_code    = exc_prio(has_int, wb_exc_vec);

    // State register and redirect target captured at the trigger edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_target <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_trap)     r_target <= ex_entry;
            else if (w_ret) r_target <= ertn_entry;
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        w_state_next   = r_state;
        wb_ex          = 1'b0;
        ertn_flush     = 1'b0;
        wb_ecode       = 6'h00;
        wb_esubcode    = 9'd0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        case (r_state)
            ST_IDLE: begin
                wb_ex      = w_trap;
                ertn_flush = w_ret;
                if (w_trap) begin
                    wb_ecode    = w_code.ecode;
                    wb_esubcode = w_code.esub;
                end
                if (w_trap || w_ret) begin
                    pipe_flush   = 1'b1;
                    w_state_next = w_drained ? ST_REDIRECT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pipe_flush = 1'b1;
                if (w_drained) w_state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pipe_flush     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                if (redirect_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign ctrl_busy = (r_state != ST_IDLE);
    assign cnt_err   = w_inst_err || w_data_err;

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// tb/tb_excp_flush_ctrl.sv - scoreboard bench for excp_flush_ctrl
module tb_excp_flush_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic [5:0]  wb_exc_vec;
    logic        wb_ertn;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        inst_req_hs, inst_resp_hs, data_req_hs, data_resp_hs;
    logic        redirect_ready;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        ertn_flush, pipe_flush, redirect_valid, ctrl_busy, cnt_err;
    logic [31:0] redirect_pc;

    typedef struct {
        logic       ex;
        logic       ertn;
        logic [5:0] ec;
        logic [8:0] es;
    } strobe_t;

    strobe_t     exp_strobe[$];
    logic [31:0] exp_pc[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    excp_flush_ctrl #(.CNT_W(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_exc_vec     (wb_exc_vec),
        .wb_ertn        (wb_ertn),
        .has_int        (has_int),
        .ex_entry       (ex_entry),
        .ertn_entry     (ertn_entry),
        .inst_req_hs    (inst_req_hs),
        .inst_resp_hs   (inst_resp_hs),
        .data_req_hs    (data_req_hs),
        .data_resp_hs   (data_resp_hs),
        .redirect_ready (redirect_ready),
        .wb_ex          (wb_ex),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .ertn_flush     (ertn_flush),
        .pipe_flush     (pipe_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ctrl_busy      (ctrl_busy),
        .cnt_err        (cnt_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge and clear per-cycle stimulus
    task automatic tick();
        @(posedge clk);
        #1;
        wb_valid     = 1'b0;
        wb_exc_vec   = 6'b0;
        wb_ertn      = 1'b0;
        has_int      = 1'b0;
        inst_req_hs  = 1'b0;
        inst_resp_hs = 1'b0;
        data_req_hs  = 1'b0;
        data_resp_hs = 1'b0;
    endtask

    task automatic settle();
        #3;
    endtask

    // Drive one WB instruction, push the expected strobe/target, then compare
    task automatic do_trigger(input logic intr, input logic [5:0] vec, input logic ertn);
        strobe_t e, got;
        tick();
        wb_valid   = 1'b1;
        wb_exc_vec = vec;
        wb_ertn    = ertn;
        has_int    = intr;
        e.ex   = intr | (|vec);
        e.ertn = ertn & ~e.ex;
        e.ec   = 6'h00;
        e.es   = 9'd0;
        if (intr)         e.ec = 6'h00;
        else if (vec[0])  e.ec = 6'h08;
        else if (vec[1])  e.ec = 6'h0D;
        else if (vec[2])  e.ec = 6'h0B;
        else if (vec[3])  e.ec = 6'h0C;
        else if (vec[4])  e.ec = 6'h09;
        else if (vec[5]) begin e.ec = 6'h08; e.es = 9'd1; end
        exp_strobe.push_back(e);
        exp_pc.push_back(e.ex ? ex_entry : ertn_entry);
        settle();
        got = exp_strobe.pop_front();
        n_chk++;
        if (wb_ex !== got.ex || ertn_flush !== got.ertn || wb_ecode !== got.ec ||
            wb_esubcode !== got.es || pipe_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL trigger: ex=%b ertn=%b ec=%h es=%h flush=%b required ex=%b ertn=%b ec=%h es=%h flush=1",
                     wb_ex, ertn_flush, wb_ecode, wb_esubcode, pipe_flush, got.ex, got.ertn, got.ec, got.es);
        end
    endtask

    // Accept the redirect with ready=1; it must show up exactly exp_wait cycles on
    task automatic expect_redirect(input int exp_wait);
        int waited = 0;
        logic [31:0] pc;
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            redirect_ready = 1'b1;
            waited++;
            settle();
            if (redirect_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        pc = exp_pc.pop_front();
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL redirect_timeout: no redirect_valid within 40 cycles, required pc %h", pc);
        end else if (waited != exp_wait || redirect_pc !== pc || wb_ex !== 1'b0 || ertn_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect: after %0d cycles pc=%h ex=%b ertn=%b required after %0d cycles pc=%h ex=0 ertn=0",
                     waited, redirect_pc, wb_ex, ertn_flush, exp_wait, pc);
        end
        tick();
        redirect_ready = 1'b0;
        settle();
        n_chk++;
        if (ctrl_busy !== 1'b0 || pipe_flush !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: busy=%b flush=%b rv=%b required 0 0 0",
                     ctrl_busy, pipe_flush, redirect_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        settle();
        n_chk++;
        if ({wb_ex, ertn_flush, pipe_flush, redirect_valid, ctrl_busy, cnt_err} !== 6'b0 ||
            redirect_pc !== 32'h0 || wb_ecode !== 6'h0 || wb_esubcode !== 9'h0) begin
            n_fail++;
            $display("FAIL reset: ex=%b ertn=%b flush=%b rv=%b busy=%b err=%b pc=%h required all 0",
                     wb_ex, ertn_flush, pipe_flush, redirect_valid, ctrl_busy, cnt_err, redirect_pc);
        end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_sys();
        ex_entry   = 32'h1C008000;
        ertn_entry = 32'h1C0000F0;
        do_trigger(1'b0, 6'b000100, 1'b0);
        expect_redirect(1);
    endtask

    task automatic test_priority();
        ex_entry = 32'h1C008040;
        do_trigger(1'b1, 6'b010001, 1'b0);
        expect_redirect(1);
        do_trigger(1'b0, 6'b000011, 1'b0);
        expect_redirect(1);
        do_trigger(1'b0, 6'b100000, 1'b0);
        expect_redirect(1);
        do_trigger(1'b0, 6'b001000, 1'b0);
        expect_redirect(1);
    endtask

    task automatic test_drain();
        tick();
        inst_req_hs = 1'b1;
        data_req_hs = 1'b1;
        tick();
        inst_req_hs = 1'b1;
        ertn_entry  = 32'h1C000100;
        do_trigger(1'b0, 6'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) inst_resp_hs = 1'b1;
            else       data_resp_hs = 1'b1;
            settle();
            n_chk++;
            if (redirect_valid !== 1'b0 || pipe_flush !== 1'b1 || ertn_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_hold%0d: rv=%b flush=%b ertn=%b required 0 1 0",
                         i, redirect_valid, pipe_flush, ertn_flush);
            end
        end
        expect_redirect(1);
    endtask

    task automatic test_ertn_vs_trap();
        ex_entry   = 32'h1C008000;
        ertn_entry = 32'h1C000200;
        do_trigger(1'b0, 6'b010000, 1'b1);
        expect_redirect(1);
    endtask

    task automatic test_same_cycle();
        tick();
        data_req_hs = 1'b1;
        do_trigger(1'b0, 6'b000100, 1'b0);
        tick();
        data_req_hs  = 1'b1;
        data_resp_hs = 1'b1;
        tick();
        settle();
        n_chk++;
        if (redirect_valid !== 1'b0 || ctrl_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_hold: rv=%b busy=%b required 0 1", redirect_valid, ctrl_busy);
        end
        data_resp_hs = 1'b1;
        expect_redirect(1);
    endtask

    task automatic test_hold();
        ex_entry = 32'h1C008080;
        do_trigger(1'b0, 6'b000010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            redirect_ready = 1'b0;
            if (i == 2) begin
                wb_valid = 1'b1;
                has_int  = 1'b1;
            end
            settle();
            n_chk++;
            if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc[0] || wb_ex !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d: rv=%b pc=%h ex=%b required 1 %h 0",
                         i, redirect_valid, redirect_pc, wb_ex, exp_pc[0]);
            end
        end
        expect_redirect(1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            tick();
            inst_req_hs = 1'b1;
        end
        tick();
        settle();
        n_chk++;
        if (cnt_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_err: cnt_err=%b required 1", cnt_err);
        end
        do_trigger(1'b0, 6'b001000, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            inst_resp_hs = 1'b1;
            settle();
            n_chk++;
            if (redirect_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL overflow_drain%0d: rv=%b required 0", i, redirect_valid);
            end
        end
        expect_redirect(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] pc;
        do_trigger(1'b0, 6'b000100, 1'b0);
        pc = exp_pc.pop_front();
        tick();
        redirect_ready = 1'b0;
        settle();
        n_chk++;
        if (redirect_valid !== 1'b1 || redirect_pc !== pc) begin
            n_fail++;
            $display("FAIL pre_reset: rv=%b pc=%h required 1 %h", redirect_valid, redirect_pc, pc);
        end
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        n_chk++;
        if ({wb_ex, ertn_flush, pipe_flush, redirect_valid, ctrl_busy, cnt_err} !== 6'b0 ||
            redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ex=%b ertn=%b flush=%b rv=%b busy=%b err=%b pc=%h required all 0",
                     wb_ex, ertn_flush, pipe_flush, redirect_valid, ctrl_busy, cnt_err, redirect_pc);
        end
        n_chk++;
        if (exp_strobe.size() != 0 || exp_pc.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d strobes %0d pcs pending required 0 0",
                     exp_strobe.size(), exp_pc.size());
        end
    endtask

    initial begin
        resetn         = 1'b0;
        redirect_ready = 1'b0;
        ex_entry       = 32'h0;
        ertn_entry     = 32'h0;
        wb_valid       = 1'b0;
        wb_exc_vec     = 6'b0;
        wb_ertn        = 1'b0;
        has_int        = 1'b0;
        inst_req_hs    = 1'b0;
        inst_resp_hs   = 1'b0;
        data_req_hs    = 1'b0;
        data_resp_hs   = 1'b0;
        test_reset();
        test_sys();
        test_priority();
        test_drain();
        test_ertn_vs_trap();
        test_same_cycle();
        test_hold();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/excp_flush_ctrl.md
Name: excp_flush_ctrl

Overview:
- Exception/ERTN sequencer sitting between the WB stage and the CSR file.
- Prioritises the exception sources tagged on the WB instruction plus the pending interrupt, and pulses the CSR commit strobes (wb_ex / ertn_flush with ecode/esubcode).
- Holds a pipeline-wide flush until all outstanding instruction and data bus transactions drain, then issues a single redirect to the exception entry or ERA.

Parameters:
- CNT_W, 4, width of each outstanding-transaction counter (max 2^CNT_W-1 in flight).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wb_valid  in  1  WB holds a valid instruction this cycle
- wb_exc_vec  in  6  {adem, ale, brk, sys, ine, adef} exception tags of WB instruction
- wb_ertn  in  1  WB instruction is ERTN
- has_int  in  1  CSR interrupt pending and enabled
- ex_entry  in  32  exception entry address from CSR
- ertn_entry  in  32  ERA value from CSR
- inst_req_hs  in  1  instruction-bus request handshake
- inst_resp_hs  in  1  instruction-bus response handshake
- data_req_hs  in  1  data-bus request handshake
- data_resp_hs  in  1  data-bus response handshake
- redirect_ready  in  1  fetch unit accepts redirect
- wb_ex  out  1  exception commit strobe to CSR
- wb_ecode  out  6  exception code to CSR
- wb_esubcode  out  9  exception subcode to CSR
- ertn_flush  out  1  ERTN commit strobe to CSR
- pipe_flush  out  1  flush/kill all stages, block new bus requests
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- ctrl_busy  out  1  state != IDLE
- cnt_err  out  1  sticky counter overflow/underflow flag

Behaviour:
- Reset: state IDLE, both counters 0, target 0, cnt_err 0; all outputs 0.
- Trigger (IDLE only): trap = wb_valid & (has_int | |wb_exc_vec); ret = wb_valid & wb_ertn & ~trap.
- Priority, highest first: INT(ecode 0x00, esub 0), ADEF(0x08, 0), INE(0x0D, 0), SYS(0x0B, 0), BRK(0x0C, 0), ALE(0x09, 0), ADEM(0x08, 1).
- In the trigger cycle, combinational outputs:
  - wb_ex=trap; ertn_flush=ret; ecode/esub per winner (0 when no trap); pipe_flush=1.
  - Exactly one cycle each; trap beats ERTN on the same instruction.
- Target register captured at trigger clock edge: trap ? ex_entry : ertn_entry.
- Next state after trigger: DRAIN if the post-update counters are nonzero, else REDIRECT.
- DRAIN: pipe_flush=1; wb inputs ignored; advance to REDIRECT on the first cycle both post-update counters are 0.
- REDIRECT: pipe_flush=1, redirect_valid=1, redirect_pc=target (stable while waiting). On redirect_ready go to IDLE; pipe_flush drops the following cycle.
- In non-IDLE states, wb_valid, wb_exc_vec, wb_ertn and has_int have no effect (no nested trigger).
- Counters (each, every state):
  - cnt_next = cnt + req_hs - resp_hs; simultaneous req and resp leaves the count unchanged.
  - Increment at max or decrement at 0: counter holds and cnt_err sets (cleared only by reset).
  - Requests during flush are still counted.
- ctrl_busy = (state != IDLE).
- Reset asserted mid-DRAIN/REDIRECT: next cycle IDLE, counters 0, redirect_valid 0, no residual strobes.
- Latency: CSR strobe in trigger cycle; earliest redirect_valid = trigger+1.

Decomposition:
- Shared package: ECODE_INT/ADE/ALE/SYS/BRK/INE, ESUB_ADEF/ADEM, exc_vec bit indices, state encoding IDLE/DRAIN/REDIRECT.
- One sub-module, outst_counter (CNT_W, req, resp, cnt, zero_next, err), instantiated for the instruction bus and the data bus.

Test Plan:
- Counters 0; wb_valid with exc_vec=sys, ex_entry=0x1C008000 -> wb_ex=1 for 1 cycle, ecode=0x0B, esub=0; redirect_valid at T+1 with pc 0x1C008000; ready at T+1 -> IDLE at T+2, pipe_flush=0.
- has_int=1 plus exc_vec={adef,ale} in the same cycle -> ecode=0x00; exc_vec={adef,ine} -> ecode=0x08, esub=0; exc_vec={adem} only -> ecode=0x08, esub=1.
- Two inst and one data request outstanding, then wb_ertn with ertn_entry=0x1C000100 -> ertn_flush 1 cycle, wb_ex=0; stays in DRAIN until the 3rd response; redirect 0x1C000100 the cycle after.
- wb_ertn and ale together -> wb_ex=1, ecode=0x09, ertn_flush=0, target=ex_entry.
- In DRAIN with count 1, a req and a resp in the same cycle -> count stays 1, no exit; 16 requests with CNT_W=4 -> cnt_err=1 and counter holds at 15.
- Hold redirect_ready=0 for 5 cycles -> redirect_pc stable, a new WB trap is ignored; resetn=0 during REDIRECT -> all outputs 0 the next cycle.
